// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register for the 5-stage 32-bit CPU, with
//               integrated load-use hazard detection. Captures decoded
//               operands, register addresses and the WB/M/EX control groups
//               from ID and presents them to EX. On a load-use hazard it
//               asserts stall_o (hold PC and IF/ID) and inserts a bubble.
//               A branch flush also inserts a bubble.
// Revision    : 1.0 - initial release
//
// Optional    : define ID_EX_PERF_EN to add bubble_cnt_o, a saturating
//               32-bit count of bubbles inserted while out of reset.
//
// Ports
//   clk_i            in   clock, all state on rising edge
//   rst_i            in   synchronous active-high reset
//   IF_ID_RSaddr_i   in   rs of instruction in ID
//   IF_ID_RTaddr_i   in   rt of instruction in ID
//   RDaddr_i         in   rd of instruction in ID
//   RSdata_i         in   register-file rs read data
//   RTdata_i         in   register-file rt read data
//   imm_i            in   sign-extended immediate
//   WB_i             in   [1]=RegWrite [0]=MemtoReg
//   M_i              in   [1]=MemRead  [0]=MemWrite
//   EX_i             in   [3]=RegDst [2]=ALUSrc [1:0]=ALUOp
//   flush_i          in   branch taken: squash ID instruction
//   ID_EX_*_o        out  registered fields presented to EX
//   ID_EX_valid_o    out  1 = real instruction, 0 = bubble
//   stall_o          out  combinational: hold PC and IF/ID this cycle
//   bubble_cnt_o     out  (ID_EX_PERF_EN only) saturating bubble count
// ============================================================================
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] IF_ID_RSaddr_i,
  input  logic [ADDR_W-1:0] IF_ID_RTaddr_i,
  input  logic [ADDR_W-1:0] RDaddr_i,
  input  logic [DATA_W-1:0] RSdata_i,
  input  logic [DATA_W-1:0] RTdata_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [1:0]        WB_i,
  input  logic [1:0]        M_i,
  input  logic [3:0]        EX_i,
  input  logic              flush_i,
  output logic [ADDR_W-1:0] ID_EX_RSaddr_o,
  output logic [ADDR_W-1:0] ID_EX_RTaddr_o,
  output logic [ADDR_W-1:0] ID_EX_RDaddr_o,
  output logic [DATA_W-1:0] ID_EX_RSdata_o,
  output logic [DATA_W-1:0] ID_EX_RTdata_o,
  output logic [DATA_W-1:0] ID_EX_imm_o,
  output logic [1:0]        ID_EX_WB_o,
  output logic [1:0]        ID_EX_M_o,
  output logic [3:0]        ID_EX_EX_o,
  output logic              ID_EX_valid_o,
  output logic              stall_o
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]       bubble_cnt_o
`endif
);

  logic [ADDR_W-1:0] r_rs_addr;
  logic [ADDR_W-1:0] r_rt_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [1:0]        r_wb;
  logic [1:0]        r_m;
  logic [3:0]        r_ex;
  logic              r_valid;

  logic              w_stall;
  logic              w_bubble;

  // A load in EX whose destination (rt) is read by the ID instruction.
  // The rt compare is applied even when the ID instruction does not read rt;
  // this costs an occasional extra stall but never misses a hazard.
  // A load to register 0 never creates a dependency.
  assign w_stall = r_valid & r_m[1] & (r_rt_addr != '0) &
                   ((r_rt_addr == IF_ID_RSaddr_i) | (r_rt_addr == IF_ID_RTaddr_i));

  assign w_bubble = flush_i | w_stall;

  // Bubbles zero every field, so the forwarding unit sees no address match,
  // the hazard check sees no load, and EX/MEM sees no RegWrite/MemWrite.
  always_ff @(posedge clk_i) begin
    if (rst_i || w_bubble) begin
      r_rs_addr <= '0;
      r_rt_addr <= '0;
      r_rd_addr <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_wb      <= '0;
      r_m       <= '0;
      r_ex      <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_rs_addr <= IF_ID_RSaddr_i;
      r_rt_addr <= IF_ID_RTaddr_i;
      r_rd_addr <= RDaddr_i;
      r_rs_data <= RSdata_i;
      r_rt_data <= RTdata_i;
      r_imm     <= imm_i;
      r_wb      <= WB_i;
      r_m       <= M_i;
      r_ex      <= EX_i;
      r_valid   <= 1'b1;
    end
  end

`ifdef ID_EX_PERF_EN
  localparam logic [31:0] c_CNT_MAX = 32'hFFFF_FFFF;

  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && (r_bubble_cnt != c_CNT_MAX)) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign bubble_cnt_o = r_bubble_cnt;
`endif

  assign ID_EX_RSaddr_o = r_rs_addr;
  assign ID_EX_RTaddr_o = r_rt_addr;
  assign ID_EX_RDaddr_o = r_rd_addr;
  assign ID_EX_RSdata_o = r_rs_data;
  assign ID_EX_RTdata_o = r_rt_data;
  assign ID_EX_imm_o    = r_imm;
  assign ID_EX_WB_o     = r_wb;
  assign ID_EX_M_o      = r_m;
  assign ID_EX_EX_o     = r_ex;
  assign ID_EX_valid_o  = r_valid;
  assign stall_o        = w_stall;

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register with integrated load-use hazard detection for the 5-stage 32-bit CPU. It captures decoded operands, register addresses and control groups from ID and presents them to EX. These outputs feed the forwarding unit's RS/RT address inputs and the EX-stage operand muxes. Detects load-use hazards, stalls PC and IF/ID, and inserts a bubble; also inserts a bubble on branch flush.

Parameters:
DATA_W, 32, width of operand/immediate data
ADDR_W, 5, register address width

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous active-high reset
IF_ID_RSaddr_i  in  ADDR_W  rs of instruction currently in ID
IF_ID_RTaddr_i  in  ADDR_W  rt of instruction currently in ID
RDaddr_i  in  ADDR_W  rd of instruction in ID
RSdata_i  in  DATA_W  register-file read data for rs
RTdata_i  in  DATA_W  register-file read data for rt
imm_i  in  DATA_W  sign-extended immediate
WB_i  in  2  [1]=RegWrite, [0]=MemtoReg
M_i  in  2  [1]=MemRead, [0]=MemWrite
EX_i  in  4  [3]=RegDst, [2]=ALUSrc, [1:0]=ALUOp
flush_i  in  1  branch taken: squash instruction in ID
ID_EX_RSaddr_o  out  ADDR_W  registered rs (to forwarding unit)
ID_EX_RTaddr_o  out  ADDR_W  registered rt (to forwarding unit, RegDst mux)
ID_EX_RDaddr_o  out  ADDR_W  registered rd
ID_EX_RSdata_o  out  DATA_W  registered rs data
ID_EX_RTdata_o  out  DATA_W  registered rt data
ID_EX_imm_o  out  DATA_W  registered immediate
ID_EX_WB_o  out  2  registered WB group
ID_EX_M_o  out  2  registered M group
ID_EX_EX_o  out  4  registered EX group
ID_EX_valid_o  out  1  1 = real instruction, 0 = bubble
stall_o  out  1  combinational; 1 = hold PC and IF/ID this cycle

Behaviour:
- Reset (rst_i=1 at edge): every registered output = 0, ID_EX_valid_o = 0; stall_o then evaluates to 0. Reset wins over flush/stall.
- Hazard (combinational from current registered state and ID inputs):
  stall_o = ID_EX_valid_o & ID_EX_M_o[1] & (ID_EX_RTaddr_o != 0) & ((ID_EX_RTaddr_o == IF_ID_RSaddr_i) | (ID_EX_RTaddr_o == IF_ID_RTaddr_i)).
  Conservative: rt compare applied even if ID instruction does not read rt.
- Capture each rising edge, priority: rst_i > bubble > load.
  - bubble when flush_i | stall_o: WB, M, EX groups = 0; RS/RT/RD addresses = 0 (no forwarding match possible, no false hazard); data/imm = 0; valid = 0.
  - load otherwise: all fields take ID inputs, valid = 1.
- Latency: 1 cycle ID->EX. Load-use stall lasts exactly one cycle (the bubble clears MemRead); the stalled instruction is captured on the following edge with unchanged inputs.
- flush_i and stall_o together: single bubble; stall_o still asserted that cycle (upstream gives flush priority for PC).
- Address 0 as load destination never stalls.
- Bubble fields are all-zero so downstream EX/MEM sees RegWrite=0, MemWrite=0 (no architectural side effects).
- No internal state besides pipeline fields (and the optional counter).

Optional Feature:
ID_EX_PERF_EN: when defined, adds output bubble_cnt_o [31:0] counting edges where a bubble was inserted (flush or stall) while rst_i=0; reset to 0 by rst_i; saturates at 32'hFFFF_FFFF, never wraps. When undefined the port and counter are absent; all other behaviour identical.

Test Plan:
- Reset: rst_i=1 for 2 cycles with nonzero inputs -> all outputs 0, valid=0, stall_o=0.
- Plain load: WB=2'b10, M=0, EX=4'b1010, rs=3, rt=4, RSdata=0x11 -> one edge later outputs equal inputs, valid=1, stall_o=0.
- Load-use: lw with M=2'b10, rt=8 captured; next ID has rs=8 -> stall_o=1 that cycle; next edge outputs all zero, valid=0; following edge dependent instr captured, stall_o=0.
- Load to $0: lw rt=0, next ID rs=0 -> stall_o=0, no bubble.
- Flush: flush_i=1 with valid ID inputs -> bubble captured (WB=M=EX=0, addresses 0); flush_i=1 with stall_o=1 -> one bubble only.
- ID_EX_PERF_EN: 3 stalls + 2 flushes -> bubble_cnt_o=5; rst_i mid-run -> 0; preload near max -> holds 0xFFFFFFFF.
